// File: rtl/display_pkg.sv
// display_pkg: shared constants and FSM encoding for the display share arbiter
package display_pkg;
   localparam int DIGITS = 4;
   localparam logic [3:0] BLANK_CODE = 4'hF;
   typedef enum logic [1:0] {IDLE, DWELL, OWN} state_t;
endpackage

// File: rtl/display_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search over req starting at ptr, optionally skipping owner
module rr_pick #(
   parameter int NREQ = 3,
   parameter int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   input  logic [IW-1:0]   owner,
   input  logic            excl,
   output logic            valid,
   output logic [IW-1:0]   idx
);
   int j;
   always_comb begin
      valid = 1'b0;
      idx = '0;
      j = 0;
      // walk backwards so the hit closest to ptr is written last and wins
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % NREQ;
         if (req[j] && !(excl && j == int'(owner))) begin
            valid = 1'b1;
            idx = IW'(j);
         end
      end
   end
endmodule

// File: rtl/display_share_arbiter.sv
// display_share_arbiter: round-robin owner of the 4-digit display with minimum dwell and blink
module display_share_arbiter
   import display_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int MIN_DWELL = 100_000_000,
   parameter int BLINK_HALF = 25_000_000,
   parameter logic [3:0] BLANK = BLANK_CODE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [16*NREQ-1:0]   data,
   input  logic [NREQ-1:0]      blink,
   output logic [NREQ-1:0]      grant,
   output logic [3:0]           digit0,
   output logic [3:0]           digit1,
   output logic [3:0]           digit2,
   output logic [3:0]           digit3,
   output logic                 busy
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int DW = MIN_DWELL > 1 ? $clog2(MIN_DWELL) : 1;
   localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
   state_t state, state_n;
   logic [IW-1:0] owner, ptr, pick_idx;
   logic [DW-1:0] dwell_cnt;
   logic [BW-1:0] blink_cnt;
   logic phase, phase_n, pick_valid, decide, take, blink_on, blank_out;
   logic [15:0] slices [NREQ];
   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req(req),
      .ptr(ptr),
      .owner(owner),
      .excl(state != IDLE),
      .valid(pick_valid),
      .idx(pick_idx)
   );
   // the last dwell cycle already applies the OWN rules so each grant lasts exactly MIN_DWELL cycles
   always_comb begin
      for (int i = 0; i < NREQ; i++) slices[i] = data[16*i +: 16];
      decide = state == OWN || (state == DWELL && dwell_cnt == DW'(MIN_DWELL - 1));
      take = pick_valid && (state == IDLE || decide);
      state_n = take ? DWELL : (state == IDLE || !decide) ? state : req[owner] ? OWN : IDLE;
      blink_on = state != IDLE && blink[owner];
      phase_n = (take || !blink_on) ? 1'b1 : (blink_cnt == BW'(BLINK_HALF - 1)) ? ~phase : phase;
      blank_out = state == IDLE || state_n == IDLE || !phase_n;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         owner <= '0;
         ptr <= '0;
         dwell_cnt <= '0;
         blink_cnt <= '0;
         phase <= 1'b1;
         busy <= 1'b0;
         {digit3, digit2, digit1, digit0} <= {DIGITS{BLANK}};
      end else begin
         state <= state_n;
         busy <= state_n != IDLE;
         phase <= phase_n;
         blink_cnt <= (take || !blink_on || blink_cnt == BW'(BLINK_HALF - 1)) ? '0 : blink_cnt + 1'b1;
         if (take) begin
            grant <= NREQ'(1) << pick_idx;
            owner <= pick_idx;
            ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            dwell_cnt <= '0;
         end else begin
            if (state_n == IDLE) grant <= '0;
            if (state == DWELL) dwell_cnt <= dwell_cnt + 1'b1;
         end
         {digit3, digit2, digit1, digit0} <= blank_out ? {DIGITS{BLANK}} : slices[owner];
      end
   end
endmodule

// File: tb/tb_display_share_arbiter.sv
// tb_display_share_arbiter: directed table, corner sequences and randomized model comparison
module tb_display_share_arbiter;
   localparam int NREQ = 3, MIN_DWELL = 8, BLINK_HALF = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic [NREQ-1:0] req = '0, blink = '0, grant;
   logic [16*NREQ-1:0] data = {16'h9ABC, 16'h5678, 16'h1234};
   logic [3:0] digit0, digit1, digit2, digit3;
   logic busy;
   logic [15:0] digits;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   assign digits = {digit3, digit2, digit1, digit0};
   display_share_arbiter #(.NREQ(NREQ), .MIN_DWELL(MIN_DWELL), .BLINK_HALF(BLINK_HALF)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .blink(blink), .grant(grant),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3), .busy(busy)
   );
   // reference: owner index (-1 idle), cycles shown, consecutive blinking cycles
   int m_owner, m_ptr, m_age, m_run;
   logic [NREQ-1:0] e_grant;
   logic [15:0] e_dig;
   logic e_busy;
   always @(posedge clk or posedge rst) begin
      int prev, nxt;
      bit on;
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_age = 0; m_run = 0;
         e_grant = '0; e_dig = 16'hFFFF; e_busy = 1'b0;
      end else begin
         prev = m_owner;
         nxt = prev;
         on = 1'b1;
         if (prev < 0 || m_age >= MIN_DWELL) begin
            nxt = -1;
            for (int k = 0; k < NREQ; k++)
               if (nxt < 0 && req[(m_ptr + k) % NREQ] && (m_ptr + k) % NREQ != prev) nxt = (m_ptr + k) % NREQ;
            if (nxt < 0 && prev >= 0 && req[prev]) nxt = prev;
         end
         if (nxt >= 0 && nxt != prev) begin
            m_age = 1; m_run = 0; m_ptr = (nxt + 1) % NREQ;
         end else begin
            m_age++;
            m_run = (prev >= 0 && blink[prev]) ? m_run + 1 : 0;
            on = ((m_run / BLINK_HALF) % 2) == 0;
         end
         e_dig = (prev < 0 || nxt < 0 || !on) ? 16'hFFFF : data[16*prev +: 16];
         e_grant = nxt < 0 ? '0 : NREQ'(1) << nxt;
         e_busy = nxt >= 0;
         m_owner = nxt;
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask
   task automatic do_reset();
      req = '0; blink = '0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   typedef struct {
      logic [2:0] req;
      int n;
      logic [2:0] g;
      logic [15:0] d;
      logic b;
   } vec_t;
   vec_t tbl [10];
   initial begin
      tbl[0] = '{3'b001, 1,  3'b001, 16'hFFFF, 1'b1};
      tbl[1] = '{3'b001, 1,  3'b001, 16'h1234, 1'b1};
      tbl[2] = '{3'b001, 10, 3'b001, 16'h1234, 1'b1};
      tbl[3] = '{3'b000, 1,  3'b000, 16'hFFFF, 1'b0};
      tbl[4] = '{3'b111, 1,  3'b010, 16'hFFFF, 1'b1};
      tbl[5] = '{3'b111, 7,  3'b010, 16'h5678, 1'b1};
      tbl[6] = '{3'b111, 1,  3'b100, 16'h5678, 1'b1};
      tbl[7] = '{3'b111, 1,  3'b100, 16'h9ABC, 1'b1};
      tbl[8] = '{3'b111, 7,  3'b001, 16'h9ABC, 1'b1};
      tbl[9] = '{3'b111, 1,  3'b001, 16'h1234, 1'b1};
      repeat (2) @(negedge clk);
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_digits", 32'(digits), 32'hFFFF);
      chk("reset_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         req = tbl[i].req;
         repeat (tbl[i].n) @(posedge clk);
         @(negedge clk);
         chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
         chk($sformatf("tbl%0d_digits", i), 32'(digits), 32'(tbl[i].d));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      end
      do_reset();
      req = 3'b001;
      @(negedge clk);
      repeat (2) @(negedge clk);
      req = 3'b011;
      repeat (5) @(negedge clk);
      chk("dwell_hold", 32'(grant), 32'b001);
      @(negedge clk);
      chk("dwell_switch", 32'(grant), 32'b010);
      do_reset();
      req = 3'b001; blink = 3'b001;
      @(negedge clk);
      chk("blink_first", 32'(digits), 32'hFFFF);
      repeat (3) @(negedge clk);
      chk("blink_on", 32'(digits), 32'h1234);
      @(negedge clk);
      chk("blink_off", 32'(digits), 32'hFFFF);
      chk("blink_grant", 32'(grant), 32'b001);
      chk("blink_busy", 32'(busy), 32'h1);
      @(negedge clk);
      blink = 3'b000;
      @(negedge clk);
      chk("blink_release", 32'(digits), 32'h1234);
      blink = 3'b001;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_grant", 32'(grant), 32'h0);
      chk("async_digits", 32'(digits), 32'hFFFF);
      chk("async_busy", 32'(busy), 32'h0);
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         chk("rand_grant", 32'(grant), 32'(e_grant));
         chk("rand_digits", 32'(digits), 32'(e_dig));
         chk("rand_busy", 32'(busy), 32'(e_busy));
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
         if ($urandom_range(0, 15) == 0) blink = NREQ'($urandom);
         if ($urandom_range(0, 3) == 0) data = {$urandom, $urandom};
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
